// File: rtl/dcache_dm_if.sv
// Core request/response and backing-memory signals of the direct-mapped data cache.
interface dcache_dm_if;
    logic        pipeline_en;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [2:0]  rwidth;
    logic        rsign;
    logic [2:0]  wwidth;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] rdata;
    logic        valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output pipeline_en, ren, wen, addr, rwidth, rsign, wwidth, wdata, flush, mem_ack, mem_rdata,
        input  rdata, valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  pipeline_en, ren, wen, addr, rwidth, rsign, wwidth, wdata, flush, mem_ack, mem_rdata,
        output rdata, valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with blocking line refill.
module dcache_dm #(
    parameter int unsigned LINES      = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dcache_dm_if.slave bus
);
    localparam int unsigned WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_WRITE} state_t;

    // size codes: 0 = byte, 1 = half, 2 = word (anything not 1/2 bytes is a word)
    function automatic logic [1:0] size_of(input logic [2:0] w);
        case (w)
            3'd1:    size_of = 2'd0;
            3'd2:    size_of = 2'd1;
            default: size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] byte_off(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    byte_off = a;
            2'd1:    byte_off = {a[1], 1'b0};
            default: byte_off = 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sgn);
        logic [31:0] sh;
        sh = word >> {byte_off(a, sz), 3'b000};
        case (sz)
            2'd0:    extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES][LINE_WORDS];
    logic [WSEL_W-1:0]   r_cnt;
    logic                r_wdone;
    logic [31:0]         r_laddr;
    logic [1:0]          r_lsize;
    logic                r_lsign;
    logic [31:0]         r_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_wstrb;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WSEL_W-1:0]   w_word;
    logic [IDX_W-1:0]    w_lidx;
    logic [TAG_W-1:0]    w_ltag;
    logic [WSEL_W-1:0]   w_lword;
    logic                w_hit;
    logic                w_load;
    logic                w_store;
    logic [1:0]          w_rsize;
    logic [1:0]          w_wsize;
    logic [1:0]          w_wboff;
    logic [3:0]          w_strb;
    logic [31:0]         w_wdata_sh;
    logic                w_valid;
    logic                w_refill_beat;
    logic                w_last;
    logic                w_store_hit;

    assign w_idx   = IDX_W'(bus.addr >> OFF_W);
    assign w_tag   = TAG_W'(bus.addr >> (OFF_W + IDX_W));
    assign w_word  = WSEL_W'((bus.addr >> 2) & 32'(LINE_WORDS - 1));
    assign w_lidx  = IDX_W'(r_laddr >> OFF_W);
    assign w_ltag  = TAG_W'(r_laddr >> (OFF_W + IDX_W));
    assign w_lword = WSEL_W'((r_laddr >> 2) & 32'(LINE_WORDS - 1));

    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store    = bus.pipeline_en & bus.wen;
    assign w_load     = bus.pipeline_en & bus.ren & ~bus.wen;
    assign w_rsize    = size_of(bus.rwidth);
    assign w_wsize    = size_of(bus.wwidth);
    assign w_wboff    = byte_off(bus.addr[1:0], w_wsize);
    assign w_wdata_sh = bus.wdata << {w_wboff, 3'b000};

    always_comb begin
        case (w_wsize)
            2'd0:    w_strb = 4'b0001 << w_wboff;
            2'd1:    w_strb = 4'b0011 << w_wboff;
            default: w_strb = 4'b1111;
        endcase
    end

    // A store is accepted only on the IDLE cycle right after its memory beat completed.
    always_comb begin
        w_valid = 1'b0;
        if (r_state == S_IDLE && !bus.flush) begin
            if (w_store)     w_valid = r_wdone;
            else if (w_load) w_valid = w_hit;
            else             w_valid = 1'b1;
        end
    end

    assign w_refill_beat = (r_state == S_REFILL) && bus.mem_ack;
    assign w_last        = (r_cnt == WSEL_W'(LINE_WORDS - 1));
    assign w_store_hit   = (r_state == S_IDLE) && !bus.flush && w_store && !r_wdone && w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_wdone     <= 1'b0;
            r_laddr     <= '0;
            r_lsize     <= '0;
            r_lsign     <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end else begin
                        r_wdone <= 1'b0;
                        if (w_store && !r_wdone) begin
                            r_state     <= S_WRITE;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {bus.addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata_sh;
                            r_mem_wstrb <= w_strb;
                        end else if (w_load && w_hit) begin
                            r_rdata <= extract(r_data[w_idx][w_word], bus.addr[1:0], w_rsize, bus.rsign);
                        end else if (w_load) begin
                            // Invalidate first so an abandoned refill never leaves a mixed line valid.
                            r_valid[w_idx] <= 1'b0;
                            r_state        <= S_REFILL;
                            r_cnt          <= '0;
                            r_laddr        <= bus.addr;
                            r_lsize        <= w_rsize;
                            r_lsign        <= bus.rsign;
                            r_mem_req      <= 1'b1;
                            r_mem_we       <= 1'b0;
                            r_mem_addr     <= bus.addr & ~((32'd1 << OFF_W) - 32'd1);
                            r_mem_wdata    <= '0;
                            r_mem_wstrb    <= 4'hF;
                        end
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack) begin
                        if (w_last) begin
                            r_valid[w_lidx] <= 1'b1;
                            r_mem_req       <= 1'b0;
                            r_state         <= S_RESP;
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                S_RESP: begin
                    r_rdata <= extract(r_data[w_lidx][w_lword], r_laddr[1:0], r_lsize, r_lsign);
                    r_state <= S_IDLE;
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_wdone   <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage: refill beats and byte-granular store-hit merges.
    always_ff @(posedge clk) begin
        if (w_refill_beat) begin
            r_data[w_lidx][r_cnt] <= bus.mem_rdata;
            if (w_last) r_tag[w_lidx] <= w_ltag;
        end
        if (w_store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) r_data[w_idx][w_word][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.valid     = w_valid;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: refills, hits, sub-word loads, stores, conflicts, flush and reset.
module tb_dcache_dm;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ack_dly;
    int   wcnt;
    int   waits;
    logic in_beat;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;
    logic [31:0] beat_q [$];
    logic [31:0] mem [logic [31:0]];

    dcache_dm_if bus();

    dcache_dm #(.LINES(64), .LINE_WORDS(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Backing memory: acks each beat ack_dly cycles after it appears, checks request stability.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        in_beat       = 1'b0;
        wcnt          = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.mem_ack = 1'b0;
                in_beat     = 1'b0;
            end else begin
                if (bus.mem_ack) bus.mem_ack = 1'b0;
                if (bus.mem_req) begin
                    if (!in_beat) begin
                        in_beat   = 1'b1;
                        wcnt      = 0;
                        cap_addr  = bus.mem_addr;
                        cap_wdata = bus.mem_wdata;
                        cap_wstrb = bus.mem_wstrb;
                        cap_we    = bus.mem_we;
                    end else begin
                        chk("beat_stable_addr", bus.mem_addr, cap_addr);
                        chk("beat_stable_wdata", bus.mem_wdata, cap_wdata);
                        chk("beat_stable_ctl", 32'({bus.mem_we, bus.mem_wstrb}), 32'({cap_we, cap_wstrb}));
                    end
                    if (wcnt == ack_dly) begin
                        logic [31:0] w;
                        w = rd(bus.mem_addr);
                        if (bus.mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                            mem[bus.mem_addr] = w;
                        end
                        bus.mem_rdata = w;
                        bus.mem_ack   = 1'b1;
                        last_addr     = bus.mem_addr;
                        last_wdata    = bus.mem_wdata;
                        last_wstrb    = bus.mem_wstrb;
                        last_we       = bus.mem_we;
                        beat_q.push_back(bus.mem_addr);
                        in_beat       = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic do_op(input string tag, input logic st, input logic [31:0] a, input logic [2:0] w,
                         input logic sg, input logic [31:0] d, output int nwait);
        @(negedge clk);
        beat_q.delete();
        bus.pipeline_en = 1'b1;
        bus.ren    = ~st;
        bus.wen    = st;
        bus.addr   = a;
        bus.rwidth = w;
        bus.wwidth = w;
        bus.rsign  = sg;
        bus.wdata  = d;
        #1;
        nwait = 0;
        while (!bus.valid && nwait < 200) begin
            @(negedge clk);
            #1;
            nwait++;
        end
        chk({tag, "_accept"}, 32'(bus.valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        #1;
    endtask

    task automatic refill_chk(input string tag, input logic [31:0] base);
        chk({tag, "_beats"}, 32'(beat_q.size()), 32'd4);
        chk({tag, "_beat0"}, beat_q[0], base);
        chk({tag, "_beat3"}, beat_q[3], base + 32'hC);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ack_dly = 0;
        mem[32'h1000] = 32'h11111111;
        mem[32'h1004] = 32'h22222222;
        mem[32'h1008] = 32'h33333333;
        mem[32'h100C] = 32'h44444444;
        mem[32'h1400] = 32'h9ABC8765;
        mem[32'h1404] = 32'h55555555;
        mem[32'h1408] = 32'h66666666;
        mem[32'h140C] = 32'h77777777;
        mem[32'h2000] = 32'h000080F0;
        rst_n = 1'b0;
        bus.pipeline_en = 1'b0;
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        bus.addr = '0;
        bus.rwidth = 3'd4;
        bus.rsign = 1'b0;
        bus.wwidth = 3'd4;
        bus.wdata = '0;
        bus.flush = 1'b0;
        #12;
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_valid_idle", 32'(bus.valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Request with the stage disabled is not taken.
        @(negedge clk);
        beat_q.delete();
        bus.ren = 1'b1;
        bus.addr = 32'h1000;
        #1;
        chk("pe_off_valid", 32'(bus.valid), 32'd1);
        @(negedge clk);
        bus.ren = 1'b0;
        chk("pe_off_no_req", 32'(bus.mem_req), 32'd0);

        do_op("cold_lw", 1'b0, 32'h1000, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("cold_lw", 32'h1000);
        chk("cold_lw_stall", 32'(waits > 0), 32'd1);
        chk("cold_lw_rdata", bus.rdata, 32'h11111111);

        do_op("hit_lw", 1'b0, 32'h1008, 3'd4, 1'b0, 32'h0, waits);
        chk("hit_lw_beats", 32'(beat_q.size()), 32'd0);
        chk("hit_lw_nowait", 32'(waits), 32'd0);
        chk("hit_lw_rdata", bus.rdata, 32'h33333333);

        do_op("lw2000", 1'b0, 32'h2000, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("lw2000", 32'h2000);
        chk("lw2000_rdata", bus.rdata, 32'h000080F0);
        do_op("lb_s", 1'b0, 32'h2000, 3'd1, 1'b1, 32'h0, waits);
        chk("lb_s_rdata", bus.rdata, 32'hFFFFFFF0);
        do_op("lbu", 1'b0, 32'h2000, 3'd1, 1'b0, 32'h0, waits);
        chk("lbu_rdata", bus.rdata, 32'h000000F0);
        do_op("lh_s", 1'b0, 32'h2000, 3'd2, 1'b1, 32'h0, waits);
        chk("lh_s_rdata", bus.rdata, 32'hFFFF80F0);
        do_op("lhu", 1'b0, 32'h2002, 3'd2, 1'b0, 32'h0, waits);
        chk("lhu_rdata", bus.rdata, 32'h00000000);
        chk("subword_beats", 32'(beat_q.size()), 32'd0);

        // Back-to-back hits, one per cycle.
        @(negedge clk);
        bus.ren = 1'b1; bus.addr = 32'h2000; bus.rwidth = 3'd4; bus.rsign = 1'b0;
        #1;
        chk("b2b_valid0", 32'(bus.valid), 32'd1);
        @(negedge clk);
        chk("b2b_rdata0", bus.rdata, 32'h000080F0);
        bus.addr = 32'h2001; bus.rwidth = 3'd1; bus.rsign = 1'b1;
        #1;
        chk("b2b_valid1", 32'(bus.valid), 32'd1);
        @(negedge clk);
        bus.ren = 1'b0;
        chk("b2b_rdata1", bus.rdata, 32'hFFFFFF80);

        do_op("sb_hit", 1'b1, 32'h2001, 3'd1, 1'b0, 32'h000000AB, waits);
        chk("sb_hit_beats", 32'(beat_q.size()), 32'd1);
        chk("sb_hit_addr", last_addr, 32'h2000);
        chk("sb_hit_wstrb", 32'(last_wstrb), 32'h2);
        chk("sb_hit_wdata", 32'(last_wdata[15:8]), 32'hAB);
        chk("sb_hit_we", 32'(last_we), 32'd1);
        chk("sb_rdata_hold", bus.rdata, 32'hFFFFFF80);
        do_op("lw_after_sb", 1'b0, 32'h2000, 3'd4, 1'b0, 32'h0, waits);
        chk("lw_after_sb_beats", 32'(beat_q.size()), 32'd0);
        chk("lw_after_sb_rdata", bus.rdata, 32'h0000ABF0);

        do_op("sw_miss", 1'b1, 32'h3000, 3'd4, 1'b0, 32'hDEADBEEF, waits);
        chk("sw_miss_beats", 32'(beat_q.size()), 32'd1);
        chk("sw_miss_wstrb", 32'(last_wstrb), 32'hF);
        do_op("lw3000", 1'b0, 32'h3000, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("lw3000", 32'h3000);
        chk("lw3000_rdata", bus.rdata, 32'hDEADBEEF);

        // Same-index conflict with slow memory.
        ack_dly = 3;
        do_op("cf_a", 1'b0, 32'h1000, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("cf_a", 32'h1000);
        chk("cf_a_rdata", bus.rdata, 32'h11111111);
        do_op("cf_b", 1'b0, 32'h1400, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("cf_b", 32'h1400);
        chk("cf_b_rdata", bus.rdata, 32'h9ABC8765);
        do_op("cf_c", 1'b0, 32'h1000, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("cf_c", 32'h1000);
        chk("cf_c_rdata", bus.rdata, 32'h11111111);

        // Flush drops the cached line.
        ack_dly = 0;
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_valid", 32'(bus.valid), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        do_op("post_flush", 1'b0, 32'h1004, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("post_flush", 32'h1000);
        chk("post_flush_rdata", bus.rdata, 32'h22222222);

        // Reset in the middle of a refill.
        ack_dly = 1;
        @(negedge clk);
        beat_q.delete();
        bus.ren = 1'b1; bus.addr = 32'h1400; bus.rwidth = 3'd4; bus.rsign = 1'b0;
        waits = 0;
        while (beat_q.size() < 2 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        chk("mid_two_beats", 32'(beat_q.size()), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        bus.ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 1'b0, 32'h1400, 3'd4, 1'b0, 32'h0, waits);
        refill_chk("post_rst", 32'h1400);
        chk("post_rst_rdata", bus.rdata, 32'h9ABC8765);

        do_op("lh_trunc", 1'b0, 32'h1403, 3'd2, 1'b1, 32'h0, waits);
        chk("lh_trunc_rdata", bus.rdata, 32'hFFFF9ABC);
        do_op("w7_trunc", 1'b0, 32'h1402, 3'd7, 1'b0, 32'h0, waits);
        chk("w7_trunc_rdata", bus.rdata, 32'h9ABC8765);
        chk("trunc_beats", 32'(beat_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 Parameter LINES, default 64, number of cache lines; SHALL be a power of two, >=2.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; SHALL be a power of two, >=1.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 pipeline_en  in  1  core stage enable; a request SHALL only be accepted while high.
REQ-006 ren  in  1  load request.
REQ-007 wen  in  1  store request; SHALL take priority when ren and wen are both high (ren ignored).
REQ-008 addr  in  32  byte address of the request.
REQ-009 rwidth  in  3  load width in bytes: 1, 2, 4; any other code SHALL be treated as 4.
REQ-010 rsign  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-011 wwidth  in  3  store width in bytes, same encoding as rwidth.
REQ-012 wdata  in  32  store data, right-aligned.
REQ-013 flush  in  1  invalidate all lines.
REQ-014 rdata  out  32  registered load result.
REQ-015 valid  out  1  combinational ready: request accepted on this edge when high.
REQ-016 mem_req / mem_we  out  1 / 1  backing-memory request strobe / write select.
REQ-017 mem_addr  out  32  word-aligned memory address (bits 1:0 = 0).
REQ-018 mem_wdata / mem_wstrb  out  32 / 4  store data lane-shifted / byte enables.
REQ-019 mem_ack  in  1  memory completes current beat; mem_rdata  in  32  read beat data, valid with mem_ack.

Function
REQ-020 Address split: offset = log2(LINE_WORDS)+2 LSBs, index = next log2(LINES) bits, tag = remaining MSBs; storage is direct-mapped flop arrays (valid bit, tag, data per line).
REQ-021 Sub-word addresses SHALL be truncated to natural alignment (half: addr[0] ignored, word: addr[1:0] ignored).
REQ-022 FSM states IDLE, REFILL, RESP, WRITE; reset state IDLE.
REQ-023 valid SHALL be 1 in IDLE when no request is pending (pipeline_en=0 or ren=wen=0) or a load hits; 0 on load miss, on any store in IDLE, and in REFILL, RESP, WRITE.
REQ-024 Load hit in IDLE: rdata SHALL update on the accepting edge (1-cycle latency) with lane-selected, extended data; back-to-back hits SHALL sustain one per cycle.
REQ-025 rdata SHALL hold its value until the next load completes; stores and idle cycles SHALL NOT change it.
REQ-026 Load miss: IDLE->REFILL; LINE_WORDS read beats issued at line base, ascending word order, mem_we=0, mem_wstrb=4'hF.
REQ-027 mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb SHALL stay stable from mem_req rise until the cycle mem_ack is sampled high; next beat may start the following cycle.
REQ-028 Each acked refill beat SHALL be written into the line; after the last beat valid/tag SHALL be set and FSM -> RESP.
REQ-029 RESP: rdata SHALL be produced from the refilled line, FSM -> IDLE, valid reasserts so the held request is then accepted as a hit.
REQ-030 Store (write-through, no-write-allocate): IDLE->WRITE, one memory beat with mem_we=1, strobes per width and addr[1:0]; on tag hit the cached bytes SHALL be updated in the same edge; on mem_ack -> IDLE and valid=1 for one cycle to accept the store; a miss SHALL NOT allocate.
REQ-031 flush in IDLE SHALL clear all valid bits in one cycle and hold valid=0 that cycle; flush outside IDLE SHALL be held off until return to IDLE.
REQ-032 mem_ack outside REFILL/WRITE SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately (asynchronously) force: FSM IDLE, all line valid bits 0, refill counter 0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-034 Reset during REFILL or WRITE SHALL abandon the transaction; no partial line SHALL be marked valid.
REQ-035 After rst_n deasserts, first request SHALL be evaluated on the next rising edge.

Verification
REQ-036 Cold load word 0x0000_1000 (memory words 0x11111111,0x22222222,0x33333333,0x44444444 from 0x1000) -> 4 beats at 0x1000..0x100C, rdata=0x11111111; then load 0x1008 -> hit, rdata=0x33333333 next edge, no mem_req.
REQ-037 Word at 0x2000 = 0x0000_80F0, cached: lb 0x2000 signed -> 0xFFFF_FFF0; lbu -> 0x0000_00F0; lh 0x2000 signed -> 0xFFFF_80F0; lhu 0x2002 -> 0x0000_0000.
REQ-038 Store byte 0xAB to cached 0x2001 -> mem_addr=0x2000, mem_wstrb=4'b0010, mem_wdata[15:8]=0xAB; subsequent lw 0x2000 hits, returns 0x0000ABF0.
REQ-039 Store to uncached 0x3000 then load 0x3000 -> store causes no refill; load misses and refills.
REQ-040 Conflict: LINES=64, LINE_WORDS=4: load 0x1000 then 0x1400 (same index) then 0x1000 -> three refills; mem_ack delayed 3 cycles per beat -> request signals stable throughout.
REQ-041 rst_n low mid-refill after beat 2 -> mem_req=0 immediately; reload of same address after reset misses and refills fully.
